instr_mem_arbiter: RTL and testbench

- Sits directly upstream of the instruction RAM/boot-ROM wrapper.
- Arbitrates two requesters onto the wrapper's single en/addr/we/be port:
  - the core instruction-fetch port (read-only, req/gnt/rvalid);
  - an external loader/debug port (read/write, req/gnt/rvalid).
- Tracks the memory's fixed 1-cycle read latency and routes returned data and rvalid to the requester that owned the access.
- Includes a starvation guard so a busy loader cannot lock out instruction fetch.

---
 rtl/instr_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_instr_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_arbiter.sv
// Arbitrates core instruction fetch and an external loader onto one 1-cycle-latency memory port.
// Define INSTR_ARB_ROUND_ROBIN_EN to replace fixed ext priority + MAX_STALL guard with round-robin.
module instr_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_STALL  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    core_req_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  output logic                    core_gnt_o,
  output logic                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  input  logic                    ext_req_i,
  input  logic [ADDR_WIDTH-1:0]   ext_addr_i,
  input  logic                    ext_we_i,
  input  logic [DATA_WIDTH/8-1:0] ext_be_i,
  input  logic [DATA_WIDTH-1:0]   ext_wdata_i,
  output logic                    ext_gnt_o,
  output logic                    ext_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ext_rdata_o,
  output logic                    ext_err_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  logic core_win;
  logic ext_win;
  logic ext_blocked;
  logic core_pend_q;
  logic ext_pend_q;
  logic err_q;
  logic ext_wr_q;

`ifdef INSTR_ARB_ROUND_ROBIN_EN
  typedef enum logic {
    WIN_CORE = 1'b0,
    WIN_EXT  = 1'b1
  } winner_e;

  winner_e last_winner_q;

  always_comb begin
    core_win = core_req_i & (~ext_req_i | (last_winner_q == WIN_EXT));
  end

  // Only contested cycles move the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_q <= WIN_CORE;
    end else if (core_req_i && ext_req_i) begin
      last_winner_q <= core_win ? WIN_CORE : WIN_EXT;
    end
  end
`else
  localparam int unsigned STALL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stall_max;

  always_comb begin
    stall_max = (stall_cnt == STALL_W'(MAX_STALL));
    core_win  = core_req_i & (~ext_req_i | stall_max);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!core_req_i || core_win) begin
      stall_cnt <= '0;
    end else if (!stall_max) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    ext_win     = ext_req_i & ~core_win;
    ext_blocked = ext_win & ext_we_i & ext_addr_i[ADDR_WIDTH-1];
    core_gnt_o  = core_win;
    ext_gnt_o   = ext_win;
  end

  // A refused boot-region write is still granted but never reaches the memory.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (core_win) begin
      mem_en_o   = 1'b1;
      mem_addr_o = core_addr_i;
      mem_be_o   = '1;
    end else if (ext_win && !ext_blocked) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = ext_addr_i;
      mem_we_o    = ext_we_i;
      mem_be_o    = ext_be_i;
      mem_wdata_o = ext_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_pend_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      ext_wr_q    <= 1'b0;
    end else begin
      core_pend_q <= core_win;
      ext_pend_q  <= ext_win;
      err_q       <= ext_blocked;
      ext_wr_q    <= ext_win & ext_we_i;
    end
  end

  always_comb begin
    core_rvalid_o = core_pend_q;
    ext_rvalid_o  = ext_pend_q;
    ext_err_o     = ext_pend_q & err_q;
    core_rdata_o  = core_pend_q ? mem_rdata_i : '0;
    ext_rdata_o   = (ext_pend_q && !ext_wr_q) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Self-checking bench for instr_mem_arbiter: directed scenarios plus constrained-random traffic
// compared against a behavioural arbitration/memory model.
module tb_instr_mem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned MAX_STALL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_req = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          ext_req = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic          ext_we = 1'b0;
  logic [BW-1:0] ext_be = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic          ext_gnt, ext_rvalid, ext_err;
  logic [DW-1:0] ext_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  instr_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_addr_i(core_addr), .core_gnt_o(core_gnt),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .ext_req_i(ext_req), .ext_addr_i(ext_addr), .ext_we_i(ext_we), .ext_be_i(ext_be),
    .ext_wdata_i(ext_wdata), .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid),
    .ext_rdata_o(ext_rdata), .ext_err_o(ext_err),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int idx);
    return 32'hC0DE_0000 ^ (idx * 32'h0001_0203);
  endfunction

  // Memory environment: responds to whatever the DUT drives on mem_*.
  logic [DW-1:0] phys_mem [int];
  always @(posedge clk) begin
    int idx;
    logic [DW-1:0] w;
    idx = int'(mem_addr >> 2);
    w = phys_mem.exists(idx) ? phys_mem[idx] : init_word(idx);
    if (mem_en && mem_we) begin
      for (int b = 0; b < BW; b++) if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
      phys_mem[idx] = w;
      mem_rdata <= $urandom;
    end else if (mem_en) begin
      mem_rdata <= w;
    end else begin
      mem_rdata <= $urandom;
    end
  end

  // Reference model state
  logic [DW-1:0] shadow [int];
  int   core_waited;
  bit   last_contest_ext;
  bit   p_core_rv, p_ext_rv, p_err;
  logic [DW-1:0] p_core_rd, p_ext_rd;
  bit   g_core, g_ext;

  function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
    int idx;
    idx = int'(a >> 2);
    return shadow.exists(idx) ? shadow[idx] : init_word(idx);
  endfunction

  task automatic model_reset();
    core_waited = 0;
    last_contest_ext = 1'b0;
    p_core_rv = 0; p_ext_rv = 0; p_err = 0;
    p_core_rd = '0; p_ext_rd = '0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    phys_mem[int'(a >> 2)] = d;
    shadow[int'(a >> 2)] = d;
  endtask

  // One clock cycle: drive at negedge, check responses and grants, advance the model.
  task automatic step(input bit cr, input logic [AW-1:0] ca, input bit er,
                      input logic [AW-1:0] ea, input bit ewe, input logic [BW-1:0] ebe,
                      input logic [DW-1:0] ewd);
    bit cw, ew, blk, contested;
    logic [DW-1:0] w;
    @(negedge clk);
    core_req = cr; core_addr = ca;
    ext_req = er; ext_addr = ea; ext_we = ewe; ext_be = ebe; ext_wdata = ewd;
    #1;
    check("core_rvalid", 64'(core_rvalid), 64'(p_core_rv));
    check("core_rdata",  64'(core_rdata),  64'(p_core_rv ? p_core_rd : '0));
    check("ext_rvalid",  64'(ext_rvalid),  64'(p_ext_rv));
    check("ext_err",     64'(ext_err),     64'(p_ext_rv & p_err));
    check("ext_rdata",   64'(ext_rdata),   64'(p_ext_rv ? p_ext_rd : '0));

    contested = cr && er;
`ifdef INSTR_ARB_ROUND_ROBIN_EN
    cw = cr && (!er || last_contest_ext);
`else
    cw = cr && (!er || core_waited == MAX_STALL);
`endif
    ew  = er && !cw;
    blk = ew && ewe && ea[AW-1];
    check("core_gnt", 64'(core_gnt), 64'(cw));
    check("ext_gnt",  64'(ext_gnt),  64'(ew));
    check("mem_en",   64'(mem_en),   64'(cw || (ew && !blk)));
    check("mem_we",   64'(mem_we),   64'(ew && !blk && ewe));
    if (cw)
      check("mem_core_drive", {mem_addr, mem_be, mem_wdata[11:0]}, {ca, {BW{1'b1}}, 12'h0});
    else if (ew && !blk)
      check("mem_ext_drive", {mem_addr, mem_be, mem_wdata[11:0]}, {ea, ebe, ewd[11:0]});
    else if (!ew)
      check("mem_idle", {mem_addr, mem_be, mem_wdata[11:0]}, 64'h0);

    // Model update for the edge that follows.
    if (contested) last_contest_ext = ew;
    if (!cr || cw) core_waited = 0;
    else if (core_waited < MAX_STALL) core_waited++;
    p_core_rv = cw;
    p_core_rd = shadow_rd(ca);
    p_ext_rv  = ew;
    p_err     = blk;
    p_ext_rd  = ewe ? '0 : shadow_rd(ea);
    if (ew && ewe && !blk) begin
      w = shadow_rd(ea);
      for (int b = 0; b < BW; b++) if (ebe[b]) w[b*8 +: 8] = ewd[b*8 +: 8];
      shadow[int'(ea >> 2)] = w;
    end
    g_core = cw;
    g_ext  = ew;
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, '0, '0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15)) << 2;
    if ($urandom_range(0, 3) == 0) a[AW-1] = 1'b1;
    return a;
  endfunction

  int core_grants, ext_grants;

  initial begin
    bit cr, er, ewe;
    logic [AW-1:0] ca, ea;
    logic [BW-1:0] ebe;
    logic [DW-1:0] ewd;

    model_reset();
    preload(16'h0010, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) preload(AW'(i * 4), 32'h1000_0000 + i * 32'h0111);
    preload(16'h0010, 32'hDEAD_BEEF);
    #1;
    check("reset_core_rvalid", 64'(core_rvalid), 64'h0);
    check("reset_ext_rvalid", 64'(ext_rvalid), 64'h0);
    check("reset_mem_en", 64'(mem_en), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Core-only fetch
    step(1, 16'h0010, 0, '0, 0, '0, '0);
    idle();
    check("fetch_data_const", 64'(core_rdata), 64'h0000_0000_DEAD_BEEF);

    // Ext write then read back; then boot-region write refused
    step(0, '0, 1, 16'h0020, 1, 4'hF, 32'h1234_5678);
    step(0, '0, 1, 16'h0020, 0, 4'h0, '0);
    idle();
    check("ext_readback_const", 64'(ext_rdata), 64'h0000_0000_1234_5678);
    step(0, '0, 1, 16'h8004, 1, 4'hF, 32'hBAD0_BAD0);
    idle();

    // Contested requests: count grants over 20 cycles
    core_grants = 0; ext_grants = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 16'h0004, 1, 16'h0030, 0, '0, '0);
      core_grants += int'(g_core);
      ext_grants  += int'(g_ext);
    end
`ifdef INSTR_ARB_ROUND_ROBIN_EN
    check("contest_core_grants", 64'(core_grants), 64'd10);
`else
    check("contest_core_grants", 64'(core_grants), 64'd4);
`endif
    idle();

    // Back-to-back fetches
    for (int i = 0; i < 8; i++) step(1, AW'(i * 4), 0, '0, 0, '0, '0);
    idle();

    // Build up stall, then a core grant, then reset mid-response
    for (int i = 0; i < 3; i++) step(1, 16'h0008, 1, 16'h0034, 0, '0, '0);
    step(1, 16'h000C, 0, '0, 0, '0, '0);
    @(posedge clk);
    #1;
    check("pre_reset_core_rvalid", 64'(core_rvalid), 64'h1);
    rst_n = 1'b0;
    core_req = 1'b0; ext_req = 1'b0;
    #1;
    check("reset_drops_core_rvalid", 64'(core_rvalid), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    // Cleared stall count: contention restarts from zero waiting
    for (int i = 0; i < 6; i++) step(1, 16'h0008, 1, 16'h0034, 0, '0, '0);
    idle();

    // Randomised traffic; requests are held until granted
    cr = 0; er = 0; ca = '0; ea = '0; ewe = 0; ebe = '0; ewd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!cr) begin
        cr = ($urandom_range(0, 2) != 0);
        ca = AW'($urandom_range(0, 15)) << 2;
      end
      if (!er) begin
        er = ($urandom_range(0, 2) != 0);
        ea = rand_addr();
        ewe = $urandom_range(0, 1) == 1;
        ebe = BW'($urandom);
        ewd = $urandom;
      end
      step(cr, ca, er, ea, ewe, ebe, ewd);
      if (g_core) cr = 0;
      if (g_ext) er = 0;
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
